// File: rtl/processador_multiciclo_param_pkg.sv
// ============================================================================
// processador_pkg : opcodes, Tstep encodings and bus-select codes
// Rev 1.0
// ============================================================================
`default_nettype none

package processador_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DIN  = 2'd1,
    SEL_REG  = 2'd2,
    SEL_G    = 2'd3
  } bus_sel_e;

endpackage

`default_nettype wire

// File: rtl/processador_multiciclo_param_regn.sv
// ============================================================================
// regn : N-bit register with load enable and asynchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module regn #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] Q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = en ? d : q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

`default_nettype wire

// File: rtl/processador_multiciclo_param.sv
// ============================================================================
// processador_multiciclo_param : parametrised multicycle core with shared bus,
// A/G ALU path and a T0..T3 step sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module processador_multiciclo_param
  import processador_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_BITS = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [1:0]        Tstep
);

  localparam int IR_W = 3 + 2 * REG_BITS;
  localparam int NREG = 2 ** REG_BITS;

  if (DATA_W < IR_W) begin : g_width_check
    $error("DATA_W must be at least 3 + 2*REG_BITS");
  end

  tstep_e                tstep_q, tstep_d;
  bus_sel_e              bus_sel;
  logic [REG_BITS-1:0]   bus_idx;
  logic [NREG-1:0]       reg_en;
  logic                  a_en, g_en, ir_en, done;
  logic [IR_W-1:0]       ir_q;
  logic [DATA_W-1:0]     a_q, g_q, alu_d;
  logic [DATA_W-1:0]     r_q [NREG];

  logic [2:0]            opcode;
  logic [REG_BITS-1:0]   rx, ry;

  assign opcode = ir_q[IR_W-1 -: 3];
  assign rx     = ir_q[2*REG_BITS-1 -: REG_BITS];
  assign ry     = ir_q[REG_BITS-1:0];

  always_comb begin
    tstep_d = tstep_q;
    bus_sel = SEL_NONE;
    bus_idx = ry;
    reg_en  = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    ir_en   = 1'b0;
    done    = 1'b0;
    unique case (tstep_q)
      T0: begin
        if (Run) begin
          ir_en   = 1'b1;
          tstep_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV, OP_MVNZ: begin
            bus_sel    = SEL_REG;
            // mvnz tests the G left behind by the most recent ALU op
            reg_en[rx] = (opcode == OP_MV) || (g_q != '0);
            done       = 1'b1;
            tstep_d    = T0;
          end
          OP_MVI: begin
            bus_sel    = SEL_DIN;
            reg_en[rx] = 1'b1;
            done       = 1'b1;
            tstep_d    = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus_sel = SEL_REG;
            bus_idx = rx;
            a_en    = 1'b1;
            tstep_d = T2;
          end
          default: begin
            done    = 1'b1;
            tstep_d = T0;
          end
        endcase
      end
      T2: begin
        bus_sel = SEL_REG;
        g_en    = 1'b1;
        tstep_d = T3;
      end
      T3: begin
        bus_sel    = SEL_G;
        reg_en[rx] = 1'b1;
        done       = 1'b1;
        tstep_d    = T0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tstep_q <= T0;
    end else begin
      tstep_q <= tstep_d;
    end
  end

  always_comb begin
    BusWires = '0;
    case (bus_sel)
      SEL_DIN:  BusWires = DIN;
      SEL_REG:  BusWires = r_q[bus_idx];
      SEL_G:    BusWires = g_q;
      default:  BusWires = '0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SUB:  alu_d = a_q - BusWires;
      OP_AND:  alu_d = a_q & BusWires;
      default: alu_d = a_q + BusWires;
    endcase
  end

  regn #(.N(IR_W)) u_ir (
    .clk(Clock), .rst(Reset), .en(ir_en), .d(DIN[IR_W-1:0]), .Q(ir_q)
  );

  regn #(.N(DATA_W)) u_a (
    .clk(Clock), .rst(Reset), .en(a_en), .d(BusWires), .Q(a_q)
  );

  regn #(.N(DATA_W)) u_g (
    .clk(Clock), .rst(Reset), .en(g_en), .d(alu_d), .Q(g_q)
  );

  for (genvar i = 0; i < NREG; i++) begin : g_regs
    regn #(.N(DATA_W)) u_r (
      .clk(Clock), .rst(Reset), .en(reg_en[i]), .d(BusWires), .Q(r_q[i])
    );
  end

  assign Done  = done;
  assign Tstep = tstep_q;

endmodule

`default_nettype wire

// File: doc/processador_multiciclo_param.md
# processador_multiciclo_param

Parametrised successor to the 16-bit multicycle processor. It has a configurable data width and register-file size, a shared bus, an A/G ALU path, and a Tstep sequencer. The instruction set grows from mv to mv, mvi, add, sub, and, and the conditional mvnz. It sits in the same place as the original core: instructions and immediates arrive on DIN under Run, and completion is signalled on Done. BusWires and the step counter are exported for bench observation.

## Interface
- DATA_W, 16: width of DIN, the registers, A, G and BusWires.
- REG_BITS, 3: register-index field width; register file holds 2**REG_BITS registers R0..R(2**REG_BITS-1).
- Constraint: DATA_W >= 3 + 2*REG_BITS; elaboration fails otherwise.
- Clock  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Run  in  1  start request, sampled only in step T0.
- DIN  in  DATA_W  instruction word in T0; immediate word in T1 of mvi.
- Done  out  1  high during the final step of each instruction (combinational on Tstep/IR).
- BusWires  out  DATA_W  shared bus value.
- Tstep  out  2  current step, T0=0..T3=3, debug visibility.

## Operation
- Instruction word format: IR = DIN[3+2*REG_BITS-1:0] = {Opcode[2:0], Rx, Ry}. Rx is destination/first operand; Ry is source. Upper DIN bits are ignored.
- Opcodes:
  - 000 mv: Rx<-Ry.
  - 001 mvi: Rx<-DIN (next word).
  - 010 add: Rx<-Rx+Ry.
  - 011 sub: Rx<-Rx-Ry.
  - 100 and: Rx<-Rx&Ry.
  - 101 mvnz: if G!=0 then Rx<-Ry.
  - 110/111: nop.
- T0 (idle/fetch): bus=0, Done=0. If Run=1, IR<-DIN and go to T1; else stay in T0.
- T1:
  - mv: bus=Ry, Rx<-bus, Done=1, go to T0.
  - mvi: bus=DIN, Rx<-bus, Done=1, go to T0.
  - mvnz: bus=Ry, Rx written only if G!=0, Done=1, go to T0.
  - nop: bus=0, no writes, Done=1, go to T0.
  - add/sub/and: bus=Rx, A<-bus, go to T2.
- T2 (ALU ops): bus=Ry, G<-A op bus, go to T3.
- T3 (ALU ops): bus=G, Rx<-bus, Done=1, go to T0.
- Arithmetic is modulo 2**DATA_W. There are no carry or overflow flags. G keeps its value until the next ALU op; mvnz reads that retained G.
- Rx==Ry is legal: add R2,R2 doubles R2; sub R3,R3 gives 0.
- Exactly one bus source is selected per step. With no source selected, the bus is 0.

## Timing
- Reset (asynchronous, active-high) clears all registers, A, G and IR to 0 and sets Tstep=T0. With Reset high, Done=0 and BusWires=0.
- Reset mid-instruction aborts it with no partial write. The first fetch happens on the first rising edge after Reset falls, with Run=1.
- Latency, counted as rising edges from the T0 fetch edge to the edge that writes Rx:
  - mv/mvi/mvnz/nop: 1 edge, 2 cycles total including T0.
  - add/sub/and: 3 edges, 4 cycles total.
- Run held high gives back-to-back issue: a T0 follows every Done cycle, so there is one idle/fetch cycle between instructions.
- Run changes outside T0 are ignored. DIN is sampled only in T0 (instruction) and T1 of mvi (immediate).
- Done is high for exactly one cycle per instruction and never in T0.
- Register write and Tstep advance happen on the same edge. A new register value is visible on BusWires no earlier than the following step.

## Structure
- Package processador_pkg holds:
  - opcode localparams OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_MVNZ;
  - Tstep encodings T0..T3;
  - bus-select encoding.
- Sub-module regn: parametric DATA_W register with enable and asynchronous active-high clear, output Q. It is instantiated for each Rn, A, G and IR (IR at the instruction-field width). Benches may preload uut.Rn.Q.
- The top level holds the Tstep counter, the control decode, the ALU, and the bus multiplexer, generated over 2**REG_BITS registers.

## Test plan
- Reset with Run=1 and DIN=mvi word: all Q=0, BusWires=0, Done=0, Tstep=0. After release, the first fetch occurs on the next edge.
- mv R0,R1 with R1 preloaded to 10 and R0 to 11: Done=1 in T1, BusWires=10, and R0=10 after that edge, all in 2 cycles.
- mvi R2, DIN=0x00FF, then add R2,R2: R2=0x00FF, then 0x01FE. Done only in T3; A=0x00FF, G=0x01FE.
- sub R3,R4 with R3=0, R4=1 (DATA_W=16): R3=0xFFFF wraps. Then mvnz R5,R4: R5=1. Then sub R4,R4 followed by mvnz R6,R1: R6 unchanged.
- Reset asserted during T2 of add: Tstep=0 immediately, Rx is not written, all registers read 0.
- Re-elaborate with DATA_W=32 and REG_BITS=4: mv R15,R0 and add over 32-bit operands, 0xFFFFFFFF+1 -> 0. Back-to-back issue with Run held high shows Done every 2 or 4 cycles as per opcode.
